spi_mosi_frame_sequencer: RTL and testbench
===========================================

Name: spi_mosi_frame_sequencer

Overview:
Parametrised successor of the OLED MOSI byte buffer. Accepts frames of 1..N bytes, each WIDTH bits wide with a per-byte D/C flag. Feeds the frames one byte at a time to the MOSI bit serializer. Additions over the previous generation:
- one-deep pending-frame slot for gapless back-to-back frames
- selectable byte order
- abort input
- done and error strobes, busy and byte-index status

Parameters:
WIDTH, 8, bits per byte presented to the serializer
N, 8, maximum bytes per frame; i_DATA holds N slots
CNT_W, 5, width of i_N_transmit and o_BYTE_IDX; must satisfy 2^CNT_W > N
HI_FIRST, 0, 0: slot 0 (i_DATA[WIDTH-1:0], i_DC[0]) is sent first; 1: slot N-1 (i_DATA[WIDTH*N-1 -: WIDTH], i_DC[N-1]) is sent first

Ports:
i_SCK  in  1  clock; all logic on rising edge
i_RST  in  1  reset, asynchronous, active-low (0 = reset)
i_DATA  in  WIDTH*N  frame bytes, N slots
i_DC  in  N  D/C flag per slot
i_N_transmit  in  CNT_W  bytes in frame; valid range 1..N
i_START  in  1  frame request; accepted on a cycle where it is high and o_READY is high
i_ABORT  in  1  synchronous abort
i_MOSI_FINAL_BIT  in  1  pulse from serializer: current byte is on its final bit
o_DATA  out  WIDTH  byte presented to serializer
o_DC  out  1  D/C for o_DATA
o_START  out  1  high while a valid byte is presented
o_FINAL_BYTE  out  1  high while the presented byte is the last of its frame
o_READY  out  1  registered; equals NOT pending_valid
o_BUSY  out  1  high in XMIT
o_BYTE_IDX  out  CNT_W  index of presented byte within its frame, starting at 0
o_DONE  out  1  one-cycle pulse on completion of the last byte of a frame
o_ERR  out  1  one-cycle pulse when a request with i_N_transmit of 0 or greater than N is rejected

Behaviour:
- Reset (i_RST=0, async): state IDLE, pending_valid=0. All outputs 0 except o_READY=1. Internal shift register, D/C register and counters cleared.
- Frame load (shared by every load path): capture the frame into a shift register and D/C register. Present byte 0 on the next edge with o_START=1 and o_BYTE_IDX=0. o_FINAL_BYTE=1 iff n=1. Store n. Shift the remainder by WIDTH toward the send order.
- IDLE: if i_START=1 and 1 <= i_N_transmit <= N, do a frame load and go to XMIT; latency is 1 cycle from request to o_START. If i_START=1 with an invalid count: o_ERR pulses, stay IDLE, no other effect.
- XMIT, i_START accepted (o_READY=1) with a valid count: capture into the pending slot; pending_valid=1 and o_READY=0 on the next cycle. Invalid count: o_ERR pulses, nothing captured.
- XMIT, i_MOSI_FINAL_BIT=1, byte not last: present the next byte and its D/C, increment o_BYTE_IDX. Set o_FINAL_BYTE iff the new index equals n-1.
- XMIT, i_MOSI_FINAL_BIT=1, last byte: o_DONE pulses. Then, in priority order:
  1. pending_valid=1: frame load from the pending slot, clear pending_valid, stay in XMIT.
  2. Else, same-cycle valid i_START: frame load directly from the inputs (bypass), stay in XMIT.
  3. Else: go to IDLE; o_START, o_FINAL_BYTE and o_BYTE_IDX go to 0. o_DATA and o_DC hold their values.
- Back-to-back frames have no idle cycle; o_START stays high across the frame boundary.
- When i_MOSI_FINAL_BIT=0, the presented byte, D/C and index hold.
- i_ABORT=1: takes priority over all other synchronous events. Go to IDLE, clear pending_valid (o_READY=1 next cycle), clear o_START, o_FINAL_BYTE and o_BYTE_IDX. No o_DONE. An i_START in the same cycle is ignored.
- i_MOSI_FINAL_BIT in IDLE is ignored.
- A new i_START while a frame is pending (o_READY=0) is ignored; it is the requester's responsibility to hold it.
- HI_FIRST=1 mirrors slot selection: byte k comes from slot N-1-k, with D/C taken from the same slot.
- Reset asserted mid-frame: immediate return to reset values, pending frame discarded.

Test Plan:
- Single byte: i_DATA[7:0]=8'hAE, i_DC=0, n=1, i_START for 1 cycle -> next cycle o_START=1, o_DATA=AE, o_DC=0, o_FINAL_BYTE=1. On i_MOSI_FINAL_BIT: o_DONE pulse, o_START=0.
- Three bytes 8'h21, 8'h00, 8'h7F with i_DC=3'b100, HI_FIRST=0 -> o_DATA advances 21, 00, 7F on successive final-bit pulses; o_DC 0, 0, 1; o_BYTE_IDX 0, 1, 2; o_FINAL_BYTE only on 7F.
- Pending frame: frame A (n=2) in flight, frame B (n=1, 8'hB0) requested -> o_READY drops. On A's last final-bit: o_DONE pulse, o_DATA=B0 with o_START held high, o_READY=1 again.
- Bypass: frame of n=1 with i_START (frame C=8'hC1) coincident with the last final-bit, pending empty -> no idle cycle; o_DATA=C1 next cycle.
- Errors: i_N_transmit=0, then i_N_transmit=9 (N=8) -> o_ERR pulses each time, state remains IDLE, o_START stays 0.
- Abort and reset: i_ABORT mid-byte 1 of 4 with a pending frame -> next cycle IDLE, o_START=0, o_READY=1, no o_DONE. Async i_RST low mid-frame -> outputs cleared without waiting for a clock edge.

Source files
------------

// File: rtl/spi_mosi_frame_sequencer.sv
// Frame sequencer in front of the MOSI bit serializer. Accepts frames of
// 1..N bytes with per-byte D/C flags and hands them over one byte at a time.
// A one-deep pending slot and a same-cycle bypass path keep back-to-back
// frames gapless at the serializer.
module spi_mosi_frame_sequencer #(
    parameter int WIDTH    = 8,
    parameter int N        = 8,
    parameter int CNT_W    = 5,
    parameter bit HI_FIRST = 1'b0
) (
    input  logic               i_SCK,
    input  logic               i_RST,
    input  logic [WIDTH*N-1:0] i_DATA,
    input  logic [N-1:0]       i_DC,
    input  logic [CNT_W-1:0]   i_N_transmit,
    input  logic               i_START,
    input  logic               i_ABORT,
    input  logic               i_MOSI_FINAL_BIT,
    output logic [WIDTH-1:0]   o_DATA,
    output logic               o_DC,
    output logic               o_START,
    output logic               o_FINAL_BYTE,
    output logic               o_READY,
    output logic               o_BUSY,
    output logic [CNT_W-1:0]   o_BYTE_IDX,
    output logic               o_DONE,
    output logic               o_ERR
);

    localparam int FW = WIDTH * N;

    typedef enum logic [0:0] {IDLE = 1'b0, XMIT = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [FW-1:0]    shreg_q, shreg_d;
    logic [N-1:0]     dcreg_q, dcreg_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] idx_d;
    logic [WIDTH-1:0] data_d;
    logic             dc_d, start_d, final_d, done_d, err_d;
    logic [FW-1:0]    pend_data_q, pend_data_d;
    logic [N-1:0]     pend_dc_q, pend_dc_d;
    logic [CNT_W-1:0] pend_n_q, pend_n_d;
    logic             pend_valid_q, pend_valid_d;

    logic             count_ok, req_ok, req_bad;
    logic             load, load_pend;
    logic [FW-1:0]    src_data;
    logic [N-1:0]     src_dc;
    logic [CNT_W-1:0] src_n;

    // Byte order helpers: the head is the next byte to send, and the shift
    // moves the following byte into the head position.
    function automatic logic [WIDTH-1:0] head_byte(input logic [FW-1:0] v);
        return HI_FIRST ? v[FW-1 -: WIDTH] : v[WIDTH-1:0];
    endfunction

    function automatic logic [FW-1:0] shift_bytes(input logic [FW-1:0] v);
        return HI_FIRST ? (v << WIDTH) : (v >> WIDTH);
    endfunction

    function automatic logic head_dc(input logic [N-1:0] d);
        return HI_FIRST ? d[N-1] : d[0];
    endfunction

    function automatic logic [N-1:0] shift_dc(input logic [N-1:0] d);
        return HI_FIRST ? (d << 1) : (d >> 1);
    endfunction

    assign count_ok = (i_N_transmit != '0) && (i_N_transmit <= CNT_W'(N));
    assign req_ok   = i_START && o_READY && count_ok;
    assign req_bad  = i_START && o_READY && !count_ok;
    assign o_READY  = ~pend_valid_q;
    assign o_BUSY   = (state_q == XMIT);

    // Next-state and next-output decode; abort outranks every other event.
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d      = state_q;
        shreg_d      = shreg_q;
        dcreg_d      = dcreg_q;
        n_d          = n_q;
        idx_d        = o_BYTE_IDX;
        data_d       = o_DATA;
        dc_d         = o_DC;
        start_d      = o_START;
        final_d      = o_FINAL_BYTE;
        done_d       = 1'b0;
        err_d        = 1'b0;
        pend_data_d  = pend_data_q;
        pend_dc_d    = pend_dc_q;
        pend_n_d     = pend_n_q;
        pend_valid_d = pend_valid_q;
        load         = 1'b0;
        load_pend    = 1'b0;

        if (i_ABORT) begin
            state_d      = IDLE;
            pend_valid_d = 1'b0;
            start_d      = 1'b0;
            final_d      = 1'b0;
            idx_d        = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_ok)       load  = 1'b1;
                    else if (req_bad) err_d = 1'b1;
                end
                XMIT: begin
                    if (i_MOSI_FINAL_BIT && !o_FINAL_BYTE) begin
                        data_d  = head_byte(shreg_q);
                        dc_d    = head_dc(dcreg_q);
                        shreg_d = shift_bytes(shreg_q);
                        dcreg_d = shift_dc(dcreg_q);
                        idx_d   = o_BYTE_IDX + 1'b1;
                        final_d = ((o_BYTE_IDX + 1'b1) == (n_q - 1'b1));
                    end else if (i_MOSI_FINAL_BIT) begin
                        done_d = 1'b1;
                        if (pend_valid_q) begin
                            load         = 1'b1;
                            load_pend    = 1'b1;
                            pend_valid_d = 1'b0;
                        end else if (req_ok) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                            start_d = 1'b0;
                            final_d = 1'b0;
                            idx_d   = '0;
                        end
                    end
                    // A request not consumed by the bypass path parks in the slot.
                    if (req_ok && !load) begin
                        pend_data_d  = i_DATA;
                        pend_dc_d    = i_DC;
                        pend_n_d     = i_N_transmit;
                        pend_valid_d = 1'b1;
                    end else if (req_bad) begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        src_data = load_pend ? pend_data_q : i_DATA;
        src_dc   = load_pend ? pend_dc_q   : i_DC;
        src_n    = load_pend ? pend_n_q    : i_N_transmit;
        if (load) begin
            state_d = XMIT;
            data_d  = head_byte(src_data);
            dc_d    = head_dc(src_dc);
            shreg_d = shift_bytes(src_data);
            dcreg_d = shift_dc(src_dc);
            n_d     = src_n;
            idx_d   = '0;
            start_d = 1'b1;
            final_d = (src_n == CNT_W'(1));
        end
    end

    // State and datapath registers, cleared asynchronously on reset.
    always_ff @(posedge i_SCK or negedge i_RST) begin
        if (!i_RST) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q      <= IDLE;
            shreg_q      <= '0;
            dcreg_q      <= '0;
            n_q          <= '0;
            o_BYTE_IDX   <= '0;
            o_DATA       <= '0;
            o_DC         <= 1'b0;
            o_START      <= 1'b0;
            o_FINAL_BYTE <= 1'b0;
            o_DONE       <= 1'b0;
            o_ERR        <= 1'b0;
            pend_data_q  <= '0;
            pend_dc_q    <= '0;
            pend_n_q     <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            dcreg_q      <= dcreg_d;
            n_q          <= n_d;
            o_BYTE_IDX   <= idx_d;
            o_DATA       <= data_d;
            o_DC         <= dc_d;
            o_START      <= start_d;
            o_FINAL_BYTE <= final_d;
            o_DONE       <= done_d;
            o_ERR        <= err_d;
            pend_data_q  <= pend_data_d;
            pend_dc_q    <= pend_dc_d;
            pend_n_q     <= pend_n_d;
            pend_valid_q <= pend_valid_d;
        end
    end

endmodule

// File: tb/tb_spi_mosi_frame_sequencer.sv
// Directed bench for spi_mosi_frame_sequencer: a low-first instance is the
// main target, a high-first instance shares its inputs for byte-order checks.
module tb_spi_mosi_frame_sequencer;

    localparam int WIDTH = 8;
    localparam int N     = 8;
    localparam int CNT_W = 5;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [WIDTH*N-1:0] data;
    logic [N-1:0]       dc;
    logic [CNT_W-1:0]   n_tx;
    logic               start, abort, final_bit;

    logic [WIDTH-1:0]   o_data, h_data;
    logic               o_dc, o_start, o_final, o_ready, o_busy, o_done, o_err;
    logic               h_dc, h_start, h_final, h_ready, h_busy, h_done, h_err;
    logic [CNT_W-1:0]   o_idx, h_idx;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_mosi_frame_sequencer #(.WIDTH(WIDTH), .N(N), .CNT_W(CNT_W), .HI_FIRST(1'b0)) dut (
        .i_SCK(clk), .i_RST(rst_n), .i_DATA(data), .i_DC(dc), .i_N_transmit(n_tx),
        .i_START(start), .i_ABORT(abort), .i_MOSI_FINAL_BIT(final_bit),
        .o_DATA(o_data), .o_DC(o_dc), .o_START(o_start), .o_FINAL_BYTE(o_final),
        .o_READY(o_ready), .o_BUSY(o_busy), .o_BYTE_IDX(o_idx), .o_DONE(o_done), .o_ERR(o_err)
    );

    spi_mosi_frame_sequencer #(.WIDTH(WIDTH), .N(N), .CNT_W(CNT_W), .HI_FIRST(1'b1)) dut_hi (
        .i_SCK(clk), .i_RST(rst_n), .i_DATA(data), .i_DC(dc), .i_N_transmit(n_tx),
        .i_START(start), .i_ABORT(abort), .i_MOSI_FINAL_BIT(final_bit),
        .o_DATA(h_data), .o_DC(h_dc), .o_START(h_start), .o_FINAL_BYTE(h_final),
        .o_READY(h_ready), .o_BUSY(h_busy), .o_BYTE_IDX(h_idx), .o_DONE(h_done), .o_ERR(h_err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one rising edge, then settle so registered outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; data = '0; dc = '0; n_tx = '0;
        start = 1'b0; abort = 1'b0; final_bit = 1'b0;

        // Reset values
        #1;
        check("rst_ready", 32'(o_ready), 1);
        check("rst_start", 32'(o_start), 0);
        check("rst_busy",  32'(o_busy),  0);
        check("rst_data",  32'(o_data),  0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single byte frame
        data = '0; data[7:0] = 8'hAE; dc = '0; n_tx = 5'd1; start = 1'b1;
        tick(); start = 1'b0;
        check("one_start", 32'(o_start), 1);
        check("one_data",  32'(o_data),  'hAE);
        check("one_dc",    32'(o_dc),    0);
        check("one_final", 32'(o_final), 1);
        check("one_busy",  32'(o_busy),  1);
        final_bit = 1'b1;
        tick(); final_bit = 1'b0;
        check("one_done",   32'(o_done),  1);
        check("one_stop",   32'(o_start), 0);
        check("one_idle",   32'(o_busy),  0);
        check("one_holdda", 32'(o_data),  'hAE);
        tick();
        check("one_done_pulse", 32'(o_done), 0);

        // Three byte frame; high-first instance reads slots 7,6,5
        data = {8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00, 8'h7F, 8'h00, 8'h21};
        dc = 8'b0100_0100; n_tx = 5'd3; start = 1'b1;
        tick(); start = 1'b0;
        check("m0_data",  32'(o_data),  'h21);
        check("m0_dc",    32'(o_dc),    0);
        check("m0_idx",   32'(o_idx),   0);
        check("m0_final", 32'(o_final), 0);
        check("m0_hdata", 32'(h_data),  'hA1);
        check("m0_hdc",   32'(h_dc),    0);
        tick();
        check("m0_hold",  32'(o_data),  'h21);
        final_bit = 1'b1;
        tick();
        check("m1_data",  32'(o_data),  'h00);
        check("m1_dc",    32'(o_dc),    0);
        check("m1_idx",   32'(o_idx),   1);
        check("m1_final", 32'(o_final), 0);
        check("m1_hdata", 32'(h_data),  'hA2);
        check("m1_hdc",   32'(h_dc),    1);
        tick();
        check("m2_data",  32'(o_data),  'h7F);
        check("m2_dc",    32'(o_dc),    1);
        check("m2_idx",   32'(o_idx),   2);
        check("m2_final", 32'(o_final), 1);
        check("m2_hdata", 32'(h_data),  'hA3);
        check("m2_hdc",   32'(h_dc),    0);
        check("m2_hfinal", 32'(h_final), 1);
        tick(); final_bit = 1'b0;
        check("m_done",  32'(o_done),  1);
        check("m_stop",  32'(o_start), 0);
        check("m_idx0",  32'(o_idx),   0);
        tick();

        // Pending frame behind a two byte frame
        data = '0; data[15:0] = {8'h5B, 8'h5A}; dc = '0; n_tx = 5'd2; start = 1'b1;
        tick(); start = 1'b0;
        check("p_a0",     32'(o_data),  'h5A);
        check("p_ready1", 32'(o_ready), 1);
        data = '0; data[7:0] = 8'hB0; n_tx = 5'd1; start = 1'b1;
        tick(); start = 1'b0;
        check("p_ready0", 32'(o_ready), 0);
        check("p_a0hold", 32'(o_data),  'h5A);
        final_bit = 1'b1;
        tick();
        check("p_a1",     32'(o_data),  'h5B);
        check("p_a1fin",  32'(o_final), 1);
        tick(); final_bit = 1'b0;
        check("p_done",   32'(o_done),  1);
        check("p_start",  32'(o_start), 1);
        check("p_b0",     32'(o_data),  'hB0);
        check("p_ready",  32'(o_ready), 1);
        check("p_bidx",   32'(o_idx),   0);
        final_bit = 1'b1;
        tick(); final_bit = 1'b0;
        check("p_bdone",  32'(o_done),  1);
        check("p_bstop",  32'(o_start), 0);
        tick();

        // Bypass: new request coincident with the last final bit
        data = '0; data[7:0] = 8'h33; n_tx = 5'd1; start = 1'b1;
        tick(); start = 1'b0;
        check("b_x0", 32'(o_data), 'h33);
        data[7:0] = 8'hC1; start = 1'b1; final_bit = 1'b1;
        tick(); start = 1'b0; final_bit = 1'b0;
        check("b_done",  32'(o_done),  1);
        check("b_start", 32'(o_start), 1);
        check("b_c1",    32'(o_data),  'hC1);
        check("b_ready", 32'(o_ready), 1);
        final_bit = 1'b1;
        tick(); final_bit = 1'b0;
        check("b_stop",  32'(o_start), 0);
        tick();

        // Rejected counts
        n_tx = 5'd0; start = 1'b1;
        tick(); start = 1'b0;
        check("e0_err",   32'(o_err),   1);
        check("e0_start", 32'(o_start), 0);
        check("e0_busy",  32'(o_busy),  0);
        tick();
        check("e0_pulse", 32'(o_err),   0);
        n_tx = 5'd9; start = 1'b1;
        tick(); start = 1'b0;
        check("e9_err",   32'(o_err),   1);
        check("e9_start", 32'(o_start), 0);
        tick();

        // Abort mid byte 1 of 4 with a frame pending
        data = '0; data[31:0] = {8'h44, 8'h43, 8'h42, 8'h41}; n_tx = 5'd4; start = 1'b1;
        tick(); start = 1'b0;
        final_bit = 1'b1;
        tick(); final_bit = 1'b0;
        check("a_idx1", 32'(o_idx),  1);
        check("a_d1",   32'(o_data), 'h42);
        data = '0; data[7:0] = 8'hE0; n_tx = 5'd1; start = 1'b1;
        tick(); start = 1'b0;
        check("a_pend", 32'(o_ready), 0);
        abort = 1'b1; start = 1'b1;
        tick(); abort = 1'b0; start = 1'b0;
        check("a_start", 32'(o_start), 0);
        check("a_busy",  32'(o_busy),  0);
        check("a_ready", 32'(o_ready), 1);
        check("a_done",  32'(o_done),  0);
        check("a_idx0",  32'(o_idx),   0);
        check("a_final", 32'(o_final), 0);
        tick();
        check("a_stays", 32'(o_start), 0);

        // Asynchronous reset mid frame
        data = '0; data[15:0] = {8'h66, 8'h65}; n_tx = 5'd2; start = 1'b1;
        tick(); start = 1'b0;
        check("r_run", 32'(o_start), 1);
        #2 rst_n = 1'b0;
        #1;
        check("r_start", 32'(o_start), 0);
        check("r_busy",  32'(o_busy),  0);
        check("r_data",  32'(o_data),  0);
        check("r_ready", 32'(o_ready), 1);
        tick();
        rst_n = 1'b1;
        tick();
        check("r_idle", 32'(o_start), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
